// File: rtl/riscv_tb_pkg.sv
// Shared types and constants for the RISC-V run monitor:
// the controller states, verdict encodings and the default mailbox address.
package riscv_tb_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE    = 2'b00,
    RES_TOHOST  = 2'b01,
    RES_HANG    = 2'b10,
    RES_TIMEOUT = 2'b11
  } result_e;

  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones. A clear with inc set reloads to 1,
// which lets one strobe both restart and count the current event.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = inc ? W'(1) : '0;
    end else if (inc && (value_q != '1)) begin
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/riscv_run_monitor.sv
// Run controller beside riscv_top: sequences core reset, counts cycles and
// retires, and latches a sticky end-of-test verdict (tohost, hang, timeout).
module riscv_run_monitor
  import riscv_tb_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     CNT_W        = 32,
  parameter int unsigned     RESET_CYCLES = 4,
  parameter int unsigned     MAX_CYCLES   = 1000000,
  parameter int unsigned     HANG_RETIRES = 16,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = XLEN'(DEFAULT_TOHOST_ADDR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire_valid,
  input  logic [XLEN-1:0]  retire_pc,
  input  logic             dmem_we,
  input  logic [XLEN-1:0]  dmem_addr,
  input  logic [XLEN-1:0]  dmem_wdata,
  output logic             core_rst_n,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic             done,
  output logic             pass,
  output logic [1:0]       result,
  output logic [XLEN-2:0]  test_code
);

  localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned REP_W  = $clog2(HANG_RETIRES + 1);

  state_e           state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic [XLEN-1:0]  last_pc_q, last_pc_d;
  logic             last_vld_q, last_vld_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  result_e          result_q, result_d;
  logic [XLEN-2:0]  code_q, code_d;
  logic [REP_W-1:0] rep_cnt;

  logic in_run, retire_run, same_pc;
  logic tohost_hit, hang_hit, timeout_hit, end_hit;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^dmem_addr[1:0];

  assign in_run     = (state_q == RUN);
  assign retire_run = in_run && retire_valid;
  assign same_pc    = last_vld_q && (retire_pc == last_pc_q);

  assign tohost_hit = in_run && dmem_we && dmem_wdata[0] &&
                      (dmem_addr[XLEN-1:2] == TOHOST_ADDR[XLEN-1:2]);
  assign hang_hit   = retire_run && same_pc &&
                      (rep_cnt == REP_W'(HANG_RETIRES - 1));
  // Fires on the edge that advances cycle_cnt to MAX_CYCLES-1, so that is the frozen value.
  assign timeout_hit = in_run &&
                       (({1'b0, cycle_cnt} + (CNT_W+1)'(1)) == (CNT_W+1)'(MAX_CYCLES - 1));
  assign end_hit    = tohost_hit || hang_hit || timeout_hit;

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (in_run),
    .value (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (retire_run),
    .value (instret_cnt)
  );

  sat_counter #(.W(REP_W)) u_repeat (
    .clk   (clk),
    .rst   (rst),
    .clr   (retire_run && !same_pc),
    .inc   (retire_run),
    .value (rep_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HOLD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HOLD:    if (hold_q == HOLD_W'(RESET_CYCLES - 1)) state_d = RUN;
      RUN:     if (end_hit) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    hold_d       = hold_q;
    core_rst_n_d = (state_d != HOLD);
    last_pc_d    = last_pc_q;
    last_vld_d   = last_vld_q;
    done_d       = done_q;
    pass_d       = pass_q;
    result_d     = result_q;
    code_d       = code_q;

    if (state_q == HOLD) hold_d = hold_q + HOLD_W'(1);

    if (retire_run && !same_pc) begin
      last_pc_d  = retire_pc;
      last_vld_d = 1'b1;
    end

    if (in_run && end_hit) begin
      done_d = 1'b1;
      if (tohost_hit) begin
        result_d = RES_TOHOST;
        pass_d   = (dmem_wdata == XLEN'(1));
        code_d   = dmem_wdata[XLEN-1:1];
      end else if (hang_hit) begin
        result_d = RES_HANG;
        pass_d   = 1'b0;
      end else begin
        result_d = RES_TIMEOUT;
        pass_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      core_rst_n_q <= 1'b0;
      last_pc_q    <= '0;
      last_vld_q   <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      result_q     <= RES_NONE;
      code_q       <= '0;
    end else begin
      hold_q       <= hold_d;
      core_rst_n_q <= core_rst_n_d;
      last_pc_q    <= last_pc_d;
      last_vld_q   <= last_vld_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      result_q     <= result_d;
      code_q       <= code_d;
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign result     = result_q;
  assign test_code  = code_q;

endmodule
